// File: rtl/mm_pkg.sv
// Shared definitions for the systolic matmul datapath blocks.
//   DIM_DEF    : default array dimension (lanes and rows per matrix)
//   BITS_C_DEF : default signed result element width
//   row_wrap_inc() : modulo-DIM row counter step; wraps at dim-1 rather than
//                    at the counter width so non-power-of-2 DIM works.
package mm_pkg;

  localparam int DIM_DEF    = 8;
  localparam int BITS_C_DEF = 16;

  function automatic int row_wrap_inc(input int idx, input int dim);
    return (idx >= dim - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_c_deskew_shift_lane.sv
// shift_lane: enable-gated shift register of DEPTH stages, BITS wide.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance one stage on this edge
//   clr        : synchronous clear of every stage, wins over en
//   d          : value captured into stage 0
//   q          : tail stage (stage DEPTH-1)
module shift_lane #(
  parameter int DEPTH = 1,
  parameter int BITS  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  logic [BITS-1:0] stage [DEPTH];

  // NOTE: these stages are individual flops, not a RAM, so every one is reset
  // and cleared; clr has to discard in-flight data, not just hide it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage read its neighbour's
      // pre-edge value, so the loop order does not matter.
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/mem_c_deskew.sv
// mem_c_deskew: output deskew buffer for the systolic matmul array.
// Lane c of the array output lags lane 0 by c steps; lane c is delayed here by
// DIM-c steps so a whole row lines up on Cout. Each aligned row is flagged with
// a one-cycle vout pulse, tagged with row_idx, and the last row of a matrix
// also raises done.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : step enable shared with the array
//   clr        : synchronous clear, priority over en
//   vin        : a valid row starts on Cin[0] this step
//   Cin[DIM]   : skewed array outputs (signed, BITS_C wide)
//   Cout[DIM]  : deskewed row (tail of each lane)
//   vout       : one-cycle pulse, Cout holds a valid row
//   row_idx    : row number (mod DIM) of the row on Cout while vout=1
//   done       : one-cycle pulse together with vout of row DIM-1
// DIM must be at least 2.
module mem_c_deskew
  import mm_pkg::*;
#(
  parameter int BITS_C = BITS_C_DEF,
  parameter int DIM    = DIM_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     vin,
  input  logic signed [BITS_C-1:0] Cin  [DIM],
  output logic signed [BITS_C-1:0] Cout [DIM],
  output logic                     vout,
  output logic [$clog2(DIM)-1:0]   row_idx,
  output logic                     done
);

  localparam int IW = $clog2(DIM);

  // Data lanes: lane c is DIM-c deep, so element (r,c) captured at step r+c
  // reaches the tail at step r+DIM-1 for every lane.
  for (genvar c = 0; c < DIM; c++) begin : g_lane
    shift_lane #(
      .DEPTH (DIM - c),
      .BITS  (BITS_C)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (clr),
      .d     (Cin[c]),
      .q     (Cout[c])
    );
  end

  // Valid pipe: DIM-1 enable-gated stages here, and the vout register below is
  // the DIM-th stage. vout differs from a plain stage only in that it drops to
  // 0 on en=0 cycles, which makes it a single-cycle pulse per row.
  logic vtail;

  shift_lane #(
    .DEPTH (DIM - 1),
    .BITS  (1)
  ) u_valid_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .d     (vin),
    .q     (vtail)
  );

  logic          vout_d;
  logic [IW-1:0] row_inc;
  logic [IW-1:0] row_next;

  assign vout_d   = en & vtail;
  assign row_inc  = IW'(row_wrap_inc(int'(row_idx), DIM));
  // row_idx steps on the edge that ends a vout pulse; done looks ahead to the
  // value row_idx will hold during the vout being loaded on this edge.
  assign row_next = vout ? row_inc : row_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout    <= 1'b0;
      done    <= 1'b0;
      row_idx <= '0;
    end else if (clr) begin
      vout    <= 1'b0;
      done    <= 1'b0;
      row_idx <= '0;
    end else begin
      vout    <= vout_d;
      row_idx <= row_next;
      done    <= vout_d && (row_next == IW'(DIM - 1));
    end
  end

endmodule

// File: tb/tb_mem_c_deskew.sv
// Self-checking bench for mem_c_deskew (DIM=8, BITS_C=16).
// Reference model: a history of every enabled step's Cin/vin. After n enabled
// steps, Cout[c] must be the Cin[c] captured at step n-DIM+c (0 if none), and a
// row is valid when vin was set at step n-DIM. Rows are numbered mod DIM.
module tb_mem_c_deskew;

  localparam int DIM    = 8;
  localparam int BITS_C = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     en = 1'b0;
  logic                     clr = 1'b0;
  logic                     vin = 1'b0;
  logic signed [BITS_C-1:0] Cin  [DIM];
  logic signed [BITS_C-1:0] Cout [DIM];
  logic                     vout;
  logic [2:0]               row_idx;
  logic                     done;

  mem_c_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .vin     (vin),
    .Cin     (Cin),
    .Cout    (Cout),
    .vout    (vout),
    .row_idx (row_idx),
    .done    (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [15:0] hist [0:2047][DIM];
  bit          hvin [0:2047];
  int          n = 0;          // enabled steps since last clear/reset
  int          m_row = 0;      // expected row number of next valid row
  int          vout_cnt = 0;   // expected valid rows since phase start
  int          cyc = 0;
  int          done_cyc [$];
  logic [15:0] cin_drv [DIM];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    n     = 0;
    m_row = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vout"}, 16'(vout), 16'd0);
    chk({tag, "_done"}, 16'(done), 16'd0);
    chk({tag, "_row_idx"}, 16'(row_idx), 16'd0);
    for (int c = 0; c < DIM; c++) chk({tag, "_cout"}, Cout[c], 16'd0);
  endtask

  // One clock: drive inputs, wait for the edge, update model, compare.
  task automatic cycle(input bit en_v, input bit vin_v);
    bit          exp_v;
    int          idx;
    logic [15:0] e;
    en  = en_v;
    vin = vin_v;
    for (int c = 0; c < DIM; c++) Cin[c] = cin_drv[c];
    @(posedge clk);
    #1;
    cyc++;
    if (en_v) begin
      for (int c = 0; c < DIM; c++) hist[n][c] = cin_drv[c];
      hvin[n] = vin_v;
      n++;
    end
    exp_v = en_v && (n >= DIM) && hvin[n-DIM];
    chk("vout", 16'(vout), 16'(exp_v));
    for (int c = 0; c < DIM; c++) begin
      idx = n - DIM + c;
      e   = (idx >= 0) ? hist[idx][c] : 16'd0;
      chk("cout", Cout[c], e);
    end
    if (done) done_cyc.push_back(cyc);
    if (exp_v) begin
      chk("row_idx", 16'(row_idx), 16'(m_row));
      chk("done_row", 16'(done), 16'(m_row == DIM - 1));
      m_row = (m_row + 1) % DIM;
      vout_cnt++;
    end else begin
      chk("done_idle", 16'(done), 16'd0);
    end
  endtask

  function automatic logic [15:0] elem(input int mode, input int r, input int c);
    case (mode)
      0:       return 16'(16 * r + c);
      2:       return (r % 2 == 0) ? 16'(-32768 + c) : 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Drive 'rows' rows starting at enabled step 0, then flush. With toggle set,
  // every enabled step is followed by an en=0 cycle carrying junk inputs.
  task automatic run_matrix(input int rows, input bit toggle, input int mode);
    int r;
    for (int s = 0; s < rows + DIM + 1; s++) begin
      for (int c = 0; c < DIM; c++) begin
        r = s - c;
        cin_drv[c] = (r >= 0 && r < rows) ? elem(mode, r, c) : 16'($urandom);
      end
      cycle(1'b1, s < rows);
      if (toggle) begin
        for (int c = 0; c < DIM; c++) cin_drv[c] = 16'($urandom);
        cycle(1'b0, 1'($urandom));
      end
    end
  endtask

  initial begin
    for (int c = 0; c < DIM; c++) begin
      cin_drv[c] = '0;
      Cin[c]     = '0;
    end

    // reset state, asynchronously applied
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: aligned rows, en held high
    vout_cnt = 0;
    run_matrix(8, 1'b0, 0);
    chk("m1_rows", 16'(vout_cnt), 16'd8);

    // 2: same with en toggling
    vout_cnt = 0;
    run_matrix(8, 1'b1, 0);
    chk("m2_rows", 16'(vout_cnt), 16'd8);

    // 3: negative data, bit-exact
    vout_cnt = 0;
    run_matrix(8, 1'b0, 2);
    chk("m3_rows", 16'(vout_cnt), 16'd8);

    // 4: clr one cycle after the 3rd vout, five rows still in flight
    vout_cnt = 0;
    for (int s = 0; s < 20; s++) begin
      for (int c = 0; c < DIM; c++)
        cin_drv[c] = (s - c >= 0 && s - c < 8) ? elem(0, s - c, c) : 16'($urandom);
      cycle(1'b1, s < 8);
      if (vout_cnt == 3) break;
    end
    chk("pre_clr_rows", 16'(vout_cnt), 16'd3);
    clr = 1'b1;
    en  = 1'b1;
    vin = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_reset();
    check_zero("clr");
    vout_cnt = 0;
    for (int i = 0; i < DIM + 2; i++) cycle(1'b1, 1'b0);
    chk("post_clr_silent", 16'(vout_cnt), 16'd0);
    run_matrix(8, 1'b0, 1);
    chk("post_clr_rows", 16'(vout_cnt), 16'd8);

    // 5: asynchronous reset mid-matrix
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < DIM; c++) cin_drv[c] = 16'($urandom);
      cycle(1'b1, s < 8);
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vout_cnt = 0;
    for (int i = 0; i < DIM + 2; i++) cycle(1'b1, 1'b0);
    chk("post_rst_silent", 16'(vout_cnt), 16'd0);

    // 6: two matrices back-to-back
    vout_cnt = 0;
    done_cyc.delete();
    run_matrix(16, 1'b0, 1);
    chk("b2b_rows", 16'(vout_cnt), 16'd16);
    chk("b2b_done_count", 16'(done_cyc.size()), 16'd2);
    if (done_cyc.size() == 2)
      chk("b2b_done_gap", 16'(done_cyc[1] - done_cyc[0]), 16'd8);

    // 7: random enable, valid and data
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < DIM; c++) cin_drv[c] = 16'($urandom);
      cycle($urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_c_deskew.md
Name: mem_c_deskew

Overview:
Output-side counterpart of the B-operand skew buffer for the systolic matmul array. The array emits result column c of row r c steps after column 0 of that row. This block delays each lane by the complement amount, so a full aligned row of DIM results appears on Cout at once. It qualifies each row with a one-cycle vout pulse, indexes rows, and pulses done after DIM rows (one full result matrix).

Parameters:
BITS_C, 16, signed result element width
DIM, 8, array dimension; number of lanes and rows per matrix

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  step enable, same as the array's en; no state changes when 0
clr  input  1  synchronous clear, priority over en
vin  input  1  lane-0 element of a valid row is present on Cin[0] this step
Cin  input  [BITS_C-1:0] x DIM (unpacked, signed)  skewed array outputs, lane c lags lane 0 by c steps
Cout  output  [BITS_C-1:0] x DIM (unpacked, signed)  deskewed row
vout  output  1  one-cycle pulse: Cout holds a valid aligned row
row_idx  output  [$clog2(DIM)-1:0]  index of the row on Cout when vout=1
done  output  1  one-cycle pulse coincident with the vout of row DIM-1

Behaviour:
- Lane c is a shift register of depth DIM-c (lane 0 depth DIM, lane DIM-1 depth 1). Every lane advances only on edges where en=1.
- Cout[c] is the tail register of lane c. Cin[c] is always shifted in, whether or not vin is set.
- Timing: element (r,c) is captured at en-edge r+c and reaches the tail at en-edge r+DIM-1 for every c, so all lanes align.
  - Latency counts en-edges only; cycles with en=0 do not count.
- Valid pipe: a DIM-deep 1-bit shift register, fed by vin and advanced with en.
- vout register:
  - Loads 1 at an en-edge that moves a 1 into the valid-pipe tail.
  - Otherwise loads 0, including on en=0 cycles.
  - vout is therefore high for exactly one clk cycle per valid row, even when en stays high.
- Cout holds its value while en=0. Cout is not cleared after vout falls.
- row_idx:
  - Increments, wrapping DIM-1 to 0, on the cycle after each vout pulse.
  - row_idx is stable and correct during vout.
  - For non-power-of-2 DIM, the wrap happens at DIM-1, not at the counter width.
- done=1 iff vout=1 and row_idx=DIM-1. done is registered alongside vout, with no combinational path from inputs.
- Rows are counted only when valid. Gaps in vin do not reset row_idx.
- Back-to-back matrices need no idle steps: row 0 of the next matrix may follow row DIM-1 on the next step.
- clr=1 at a clock edge:
  - All lane registers, the valid pipe, row_idx, vout and done go to 0, regardless of en.
  - In-flight rows are discarded and produce no vout.
- rst_n=0 (asynchronous): same state as clr, immediately.
- Reset values: Cout all 0, vout 0, row_idx 0, done 0.
- Arithmetic: no arithmetic on data. Values pass bit-exact and sign is preserved. The only arithmetic is the row_idx increment, mod DIM.

Decomposition:
- Shared package mm_pkg (extend if present): DIM and BITS_C defaults, and an lane_vec_t typedef if the team adopts packed vectors.
- One natural sub-module: shift_lane, parameters DEPTH and BITS, ports clk, rst_n, en, clr, d, q.
  - Instantiate once per lane with DEPTH=DIM-c in a generate loop.
  - Instantiate again with BITS=1, DEPTH=DIM for the valid pipe.
- vout, row_idx and done logic stays in the top module.

Test Plan:
- DIM=8, en=1 continuously; drive Cin[c]=16*r+c at step r+c and vin=1 at steps 0..7 -> vout pulses at steps 8..15 with Cout[c]=16*r+c and row_idx=r; done only with row 7.
- Same stimulus with en toggling 1,0,1,0 -> identical row contents and order; each vout lasts one clk; Cout unchanged during en=0 cycles.
- Negative data (Cin[c]=-32768+c, and -1) -> Cout reproduces them bit-exact, sign intact.
- clr asserted one cycle after the 3rd vout with 5 rows in flight -> no further vout or done; row_idx=0; Cout=0; a new matrix then emits rows 0..7 normally.
- rst_n pulsed low mid-matrix, asynchronously between edges -> outputs go to 0 immediately; no vout from pre-reset rows.
- Two matrices back-to-back (vin high for 16 steps) -> 16 vout pulses, row_idx wraps 7 to 0, done pulses twice, 8 cycles apart.
